// File: rtl/fp16_conv_arbiter.sv
// Round-robin arbiter sharing one external fixed-point-to-FP16 converter among NUM_REQ requesters.
// Two-stage pipeline: S1 drives the converter, S2 captures its result and presents it tagged with the requester ID.
module fp16_conv_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [15:0]            conv_in,
    input  logic [15:0]            conv_out,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            rsp_data,
    input  logic                   rsp_ready,
    output logic                   busy,
    output logic [15:0]            rsp_count
);

    localparam int unsigned DATA_W = 16;

    logic                s1_valid;
    logic [DATA_W-1:0]   s1_data;
    logic [ID_W-1:0]     s1_id;
    logic                s2_valid;
    logic [DATA_W-1:0]   s2_data;
    logic [ID_W-1:0]     s2_id;
    logic [ID_W-1:0]     ptr;
    logic [DATA_W-1:0]   cnt;

    logic                s1_load;
    logic                s2_load;
    logic                any_valid;
    logic                accept;
    logic [ID_W-1:0]     grant;
    logic [ID_W-1:0]     next_ptr;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REQ-1:0]  rot;
    int unsigned         arb_idx;

    assign s2_load  = s1_valid && (!s2_valid || rsp_ready);
    assign s1_load  = !s1_valid || s2_load;
    assign accept   = any_valid && s1_load && rst_n;
    assign next_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);

    // Rotating priority search starting at the pointer; first valid requester wins.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        arb_idx   = 0;
        rot       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            arb_idx = 32'(ptr) + k;
            if (arb_idx >= NUM_REQ) begin
                arb_idx = arb_idx - NUM_REQ;
            end
            rot = req_valid >> arb_idx;
            if (!any_valid && rot[0]) begin
                any_valid = 1'b1;
                grant     = ID_W'(arb_idx);
            end
        end
    end

    // One-hot accept and operand select for the granted requester.
    always_comb begin
        req_ready = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                req_ready[i] = accept;
                sel_data     = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
            ptr      <= '0;
            cnt      <= '0;
        end else begin
            if (s1_load) begin
                if (any_valid) begin
                    s1_valid <= 1'b1;
                    s1_data  <= sel_data;
                    s1_id    <= grant;
                    ptr      <= next_ptr;
                end else begin
                    s1_valid <= 1'b0;
                end
            end

            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_data  <= conv_out;
                s2_id    <= s1_id;
            end else if (s2_valid && rsp_ready) begin
                s2_valid <= 1'b0;
            end

            if (s2_valid && rsp_ready) begin
                cnt <= cnt + DATA_W'(1);
            end
        end
    end

    assign conv_in   = s1_data;
    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_data  = s2_data;
    assign rsp_count = cnt;
    assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_fp16_conv_arbiter.sv
// Directed self-checking bench for fp16_conv_arbiter; models the external int16-to-FP16 converter.
module tb_fp16_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [15:0] conv_in;
    logic [15:0] conv_out;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_ready;
    logic        busy;
    logic [15:0] rsp_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp16_conv_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .conv_in   (conv_in),
        .conv_out  (conv_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .rsp_count (rsp_count)
    );

    // Signed integer to FP16, round to nearest even.
    function automatic logic [15:0] to_fp16(input logic [15:0] x);
        logic [16:0] mag;
        logic [16:0] man;
        logic [16:0] rem;
        logic [16:0] half;
        int          p;
        int          e;
        if (x == 16'h0) return 16'h0;
        mag = x[15] ? (17'h10000 - {1'b0, x}) : {1'b0, x};
        p = 0;
        for (int i = 0; i < 17; i++) begin
            if ((mag >> i) != 17'd0) p = i;
        end
        e = p + 15;
        if (p <= 10) begin
            man = mag << (10 - p);
        end else begin
            man  = mag >> (p - 10);
            rem  = mag & ((17'd1 << (p - 10)) - 17'd1);
            half = 17'd1 << (p - 11);
            if (rem > half || (rem == half && man[0])) man = man + 17'd1;
            if (man[11]) begin
                man = man >> 1;
                e   = e + 1;
            end
        end
        return {x[15], 5'(e), man[9:0]};
    endfunction

    assign conv_out = to_fp16(conv_in);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_op(input int r, input logic [15:0] d);
        req_data[r*16 +: 16] = d;
    endtask

    typedef struct {
        int          req;
        logic [15:0] operand;
        logic [15:0] expect_fp;
    } vec_t;

    vec_t        vecs[9];
    int          exp_cnt;
    int          accepts;
    logic [15:0] rr_fp[4];
    int          skip_id[3];
    logic [15:0] skip_fp[3];

    initial begin
        vecs[0] = '{0, 16'h0000, 16'h0000};
        vecs[1] = '{0, 16'hFFFF, 16'hBC00};
        vecs[2] = '{0, 16'h0003, 16'h4200};
        vecs[3] = '{0, 16'h8000, 16'hF800};
        vecs[4] = '{1, 16'h0400, 16'h6400};
        vecs[5] = '{3, 16'hFFF6, 16'hC900};
        vecs[6] = '{2, 16'h0801, 16'h6800};
        vecs[7] = '{1, 16'h0803, 16'h6802};
        vecs[8] = '{3, 16'h7FFF, 16'h7800};
        rr_fp   = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        skip_id = '{3, 1, 3};
        skip_fp = '{16'hCC00, 16'h4C00, 16'hCC00};

        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = '0;
        rsp_ready = 1'b1;

        // Reset state, with requests pending
        tick();
        tick();
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_count", 32'(rsp_count), 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'h0);
        chk("reset_rsp_data", 32'(rsp_data), 32'h0);
        chk("reset_conv_in", 32'(conv_in), 32'h0);

        // Single transfer from requester 2
        rst_n     = 1'b1;
        req_valid = 4'b0100;
        set_op(2, 16'h0001);
        settle();
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        chk("single_conv_in", 32'(conv_in), 32'h0001);
        chk("single_s1_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("single_s1_busy", 32'(busy), 32'h1);
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id", 32'(rsp_id), 32'h2);
        chk("single_rsp_data", 32'(rsp_data), 32'h3C00);
        tick();
        chk("single_count", 32'(rsp_count), 32'h1);
        chk("single_busy_fall", 32'(busy), 32'h0);
        chk("single_rsp_drop", 32'(rsp_valid), 32'h0);
        exp_cnt = 1;

        // Value sweep table
        for (int v = 0; v < 9; v++) begin
            req_valid = 4'(1 << vecs[v].req);
            set_op(vecs[v].req, vecs[v].operand);
            settle();
            chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(1 << vecs[v].req));
            tick();
            req_valid = 4'b0000;
            tick();
            chk($sformatf("vec%0d_valid", v), 32'(rsp_valid), 32'h1);
            chk($sformatf("vec%0d_id", v), 32'(rsp_id), 32'(vecs[v].req));
            chk($sformatf("vec%0d_data", v), 32'(rsp_data), 32'(vecs[v].expect_fp));
            tick();
            exp_cnt++;
            chk($sformatf("vec%0d_count", v), 32'(rsp_count), 32'(exp_cnt));
        end

        // Round-robin from a fresh reset, all requesters valid for 8 accepts
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) set_op(r, 16'(r + 1));
        req_valid = 4'hF;
        for (int k = 0; k < 9; k++) begin
            settle();
            if (k < 8) chk($sformatf("rr%0d_grant", k), 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            if (k >= 1) begin
                chk($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'h1);
                chk($sformatf("rr%0d_id", k), 32'(rsp_id), 32'((k - 1) % 4));
                chk($sformatf("rr%0d_data", k), 32'(rsp_data), 32'(rr_fp[(k - 1) % 4]));
            end
            if (k == 7) req_valid = 4'h0;
        end
        tick();
        chk("rr_count", 32'(rsp_count), 32'd8);
        chk("rr_idle", 32'(busy), 32'h0);

        // Backpressure: five edges with rsp_ready low, pointer at 0
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        accepts   = 0;
        for (int k = 0; k < 5; k++) begin
            settle();
            for (int r = 0; r < 4; r++) if (req_ready[r] && req_valid[r]) accepts++;
            if (k == 0) chk("bp_ready0", 32'(req_ready), 32'h1);
            if (k == 1) chk("bp_ready1", 32'(req_ready), 32'h2);
            if (k >= 2) chk($sformatf("bp%0d_ready_zero", k), 32'(req_ready), 32'h0);
            tick();
            if (k >= 1) begin
                chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'h1);
                chk($sformatf("bp%0d_id", k), 32'(rsp_id), 32'h0);
                chk($sformatf("bp%0d_data", k), 32'(rsp_data), 32'h3C00);
            end
        end
        chk("bp_accepts", 32'(accepts), 32'd2);
        chk("bp_count_held", 32'(rsp_count), 32'd8);
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_drain_id", 32'(rsp_id), 32'h1);
        chk("bp_drain_data", 32'(rsp_data), 32'h4000);
        chk("bp_drain_valid", 32'(rsp_valid), 32'h1);
        tick();
        chk("bp_drain_done", 32'(rsp_valid), 32'h0);
        chk("bp_count", 32'(rsp_count), 32'd10);

        // Pointer skip: pointer at 2, only requesters 1 and 3 valid
        set_op(1, 16'h0010);
        set_op(3, 16'hFFF0);
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            settle();
            if (k < 3) chk($sformatf("skip%0d_grant", k), 32'(req_ready), 32'(1 << skip_id[k]));
            tick();
            if (k == 2) req_valid = 4'h0;
            if (k >= 1) begin
                chk($sformatf("skip%0d_id", k), 32'(rsp_id), 32'(skip_id[k - 1]));
                chk($sformatf("skip%0d_data", k), 32'(rsp_data), 32'(skip_fp[k - 1]));
            end
        end
        tick();
        chk("skip_count", 32'(rsp_count), 32'd13);

        // Mid-operation reset with both stages full, pointer left at 3
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        tick();
        tick();
        chk("mid_full_busy", 32'(busy), 32'h1);
        chk("mid_full_valid", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        settle();
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_count", 32'(rsp_count), 32'h0);
        rst_n     = 1'b1;
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("mid_no_emit", 32'(rsp_valid), 32'h0);
        req_valid = 4'b1010;
        settle();
        chk("mid_ptr0_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'h0;
        tick();
        chk("mid_rsp_id", 32'(rsp_id), 32'h1);
        chk("mid_rsp_data", 32'(rsp_data), 32'h4C00);
        tick();
        chk("mid_count", 32'(rsp_count), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp16_conv_arbiter.md
Name: fp16_conv_arbiter

Overview:
- Shares one combinational fixed-point-to-FP16 converter among NUM_REQ requesters using round-robin arbitration.
- Uses a 2-stage pipeline: S1 is the operand register that drives the converter; S2 is the response register that captures the converter result.
- Returns each FP16 result tagged with the ID of the requester that issued it, under valid/ready backpressure.
- Sits between the control-path requesters and the single converter instance in rtl/control.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  16*NUM_REQ  operands, signed two's-complement fixed point; requester i uses bits [16i+15:16i].
- req_ready  out  NUM_REQ  per-requester accept; an operand transfers when valid and ready are both high at a clock edge.
- conv_in  out  16  operand to the external converter; equals s1_data.
- conv_out  in  16  FP16 result from the converter; combinational from conv_in.
- rsp_valid  out  1  response valid (S2 valid).
- rsp_id  out  ID_W  index of the requester that issued the response.
- rsp_data  out  16  FP16 result.
- rsp_ready  in  1  downstream accept.
- busy  out  1  high when S1 or S2 holds valid data.
- rsp_count  out  16  number of completed response handshakes; wraps at 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst_n low at an edge) clears s1_valid, s2_valid, the priority pointer (to 0) and rsp_count.
  - Reset values: rsp_valid=0, busy=0, rsp_count=0, rsp_id=0, rsp_data=0, conv_in=0.
  - Reset mid-operation discards in-flight data; nothing is emitted afterwards.
  - req_ready is all-zero while rst_n is low.
- Pipeline advance:
  - s2_load = s1_valid && (!s2_valid || rsp_ready).
  - s1_load = !s1_valid || s2_load.
- Arbitration (combinational):
  - Search req_valid starting at the pointer index, wrapping modulo NUM_REQ; the first set bit wins (grant index g).
  - req_ready[i] = (i==g) && any(req_valid) && s1_load && rst_n.
  - At most one req_ready bit is high in any cycle. req_ready never depends on req_data.
- On accept (a handshake at requester g):
  - s1_data <= operand of g; s1_id <= g; s1_valid <= 1.
  - pointer <= (g+1) mod NUM_REQ.
  - The pointer is unchanged in cycles with no accept.
- If s1_load holds but no request is valid: s1_valid <= 0.
- On s2_load: s2_data <= conv_out; s2_id <= s1_id; s2_valid <= 1.
- If s2_valid && rsp_ready && !s2_load: s2_valid <= 0.
- Simultaneous events:
  - A response handshake in the same cycle as a new S2 load keeps rsp_valid high, with new data.
  - rsp_count increments on every rsp_valid && rsp_ready.
- Latency and throughput:
  - An operand accepted at edge t appears on rsp_* after edge t+1 (two cycles).
  - With rsp_ready held high, sustained throughput is one result per cycle.
- Backpressure:
  - While rsp_valid && !rsp_ready, rsp_data and rsp_id hold stable.
  - S1 holds its data; after S1 fills, req_ready is all-zero until S2 drains.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1,0,..; any valid requester is granted within NUM_REQ accepts.
- Ordering: responses leave in grant order; there is no reordering.
- busy = s1_valid || s2_valid.

Test Plan:
- Reset then single transfer: requester 2 sends 0x0001 with rsp_ready=1 -> rsp_valid two edges later, rsp_id=2, rsp_data=0x3C00, rsp_count=1, busy falls the following cycle.
- Value sweep via requester 0: 0x0000->0x0000, 0xFFFF->0xBC00, 0x0003->0x4200, 0x8000->0xF800, all with rsp_id=0.
- Round-robin: all 4 requesters valid for 8 cycles, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3; one response per cycle; rsp_count=8.
- Backpressure: rsp_ready=0 for 5 cycles with all requesters valid -> only 2 operands accepted, rsp_data/rsp_id frozen, req_ready all-zero; on release, responses drain in order with no loss or duplication.
- Pointer skip: only requesters 1 and 3 valid, pointer at 2 -> requester 3 is granted first, then 1, then 3.
- Mid-operation reset: rst_n low for 1 cycle with both stages full -> rsp_valid=0, busy=0, rsp_count=0 after the edge; the next accepted request is arbitrated from pointer 0.
